// File: rtl/sub_rr_sched.sv
// sub_rr_sched: round-robin arbiter sharing one signed W-bit subtractor (A - B) among
// NREQ requesters. A winner is picked in StIdle, its operands are computed in StExec, and
// the result is held, tagged with the winner's ID, in StResp until res_ack.
// Optional build macro: SUB_SAT_EN makes overflowed results saturate instead of wrapping.
module sub_rr_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_bus,
  input  logic [NREQ*W-1:0] b_bus,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ack,
  output logic [W-1:0]      res,
  output logic [IDW-1:0]    res_id,
  output logic              ovp,
  output logic              ovn
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_t;

  state_t r_state, w_state_d;

  logic [IDW-1:0]  r_ptr, w_ptr_d;
  logic [W-1:0]    r_a, r_b, w_a_d, w_b_d;
  logic [IDW-1:0]  r_id, w_id_d;
  logic [NREQ-1:0] r_gnt, w_gnt_d;
  logic [W-1:0]    r_res, w_res_d;
  logic            r_ovp, r_ovn, w_ovp_d, w_ovn_d;
  logic            r_valid, w_valid_d;

  // Arbitration signals
  logic            w_any;
  logic [IDW-1:0]  w_win;
  logic [IDW-1:0]  w_cand;
  int unsigned     w_idx;

  // Shared subtractor signals
  logic [W-1:0]    w_diff;
  logic            w_ovp, w_ovn;
  logic [W-1:0]    w_sub_res;

  // Winner search: first set req bit at or above the rr pointer, wrapping modulo NREQ.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_idx  = 0;
    w_cand = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx  = (32'(r_ptr) + k) % NREQ;
      w_cand = IDW'(w_idx);
      if (!w_any && req[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  // Shared combinational subtractor fed only by the registered operands.
  always_comb begin
    w_diff = r_a - r_b;
    w_ovp  = ~r_a[W-1] &  r_b[W-1] &  w_diff[W-1];
    w_ovn  =  r_a[W-1] & ~r_b[W-1] & ~w_diff[W-1];
`ifdef SUB_SAT_EN
    if (w_ovp) begin
      w_sub_res = {1'b0, {(W-1){1'b1}}};
    end else if (w_ovn) begin
      w_sub_res = {1'b1, {(W-1){1'b0}}};
    end else begin
      w_sub_res = w_diff;
    end
`else
    w_sub_res = w_diff;
`endif
  end

  // Next-state and datapath update; every register holds unless its state acts on it.
  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_a_d     = r_a;
    w_b_d     = r_b;
    w_id_d    = r_id;
    w_gnt_d   = '0;
    w_res_d   = r_res;
    w_ovp_d   = r_ovp;
    w_ovn_d   = r_ovn;
    w_valid_d = r_valid;

    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          w_a_d          = a_bus[w_win*W +: W];
          w_b_d          = b_bus[w_win*W +: W];
          w_id_d         = w_win;
          w_gnt_d[w_win] = 1'b1;
          w_state_d      = StExec;
        end
      end
      StExec: begin
        w_res_d   = w_sub_res;
        w_ovp_d   = w_ovp;
        w_ovn_d   = w_ovn;
        w_valid_d = 1'b1;
        w_ptr_d   = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
        w_state_d = StResp;
      end
      StResp: begin
        // Ack wins over any concurrent request; new arbitration happens in the next StIdle.
        if (res_ack) begin
          w_valid_d = 1'b0;
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Datapath registers; reset aborts any in-flight or held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_id    <= '0;
      r_gnt   <= '0;
      r_res   <= '0;
      r_ovp   <= 1'b0;
      r_ovn   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_d;
      r_a     <= w_a_d;
      r_b     <= w_b_d;
      r_id    <= w_id_d;
      r_gnt   <= w_gnt_d;
      r_res   <= w_res_d;
      r_ovp   <= w_ovp_d;
      r_ovn   <= w_ovn_d;
      r_valid <= w_valid_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    gnt       = r_gnt;
    busy      = (r_state == StExec) || (r_state == StResp);
    res_valid = r_valid;
    res       = r_res;
    res_id    = r_id;
    ovp       = r_ovp;
    ovn       = r_ovn;
  end

endmodule

// File: doc/sub_rr_sched.md
Name: sub_rr_sched

Overview:
- Round-robin scheduler that shares one signed W-bit subtractor (A - B with positive/negative overflow flags) among NREQ requesters.
- Grants one requester at a time, captures its operands, computes the result, and holds it tagged with the requester ID until the consumer acknowledges.
- Sits between the requesting datapath blocks and the single shared combinational subtractor.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, operand/result width, two's complement
- IDW, 2, requester ID width, = clog2(NREQ)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req  input  NREQ  request per requester; held high until its gnt is seen
- a_bus  input  NREQ*W  packed minuend operands, requester i at bits [i*W +: W]
- b_bus  input  NREQ*W  packed subtrahend operands, same packing
- gnt  output  NREQ  one-hot, registered; high for exactly one cycle for the winner
- busy  output  1  high in EXEC and RESP
- res_valid  output  1  result valid; held until acknowledged
- res_ack  input  1  consumer accepts the result
- res  output  W  signed difference A - B
- res_id  output  IDW  index of the requester that owns res
- ovp  output  1  positive overflow (A >= 0, B < 0, true result > 2^(W-1)-1)
- ovn  output  1  negative overflow (A < 0, B >= 0, true result < -2^(W-1))

Behaviour:
- Reset, asynchronous and active-high: state = IDLE, rr pointer = 0, gnt = 0, busy = 0, res_valid = 0, res = 0, res_id = 0, ovp = 0, ovn = 0, operand registers = 0.
- Reset asserted mid-operation aborts any in-flight or held result immediately; no result is produced afterwards.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise pick the winner: the first set req bit searching from the rr pointer upward, wrapping modulo NREQ.
  - At the clock edge: capture that requester's A and B into operand registers, register res_id = winner, set gnt[winner] = 1, go to EXEC.
- EXEC (one cycle):
  - gnt is high for this cycle only.
  - Registered operands drive the subtractor.
  - At the edge: register res/ovp/ovn, set res_valid = 1, set rr pointer = (winner + 1) mod NREQ, go to RESP.
- RESP:
  - res, res_id, ovp and ovn are stable while res_valid = 1.
  - res_ack sampled high at an edge → res_valid = 0, go to IDLE.
  - res_ack while res_valid = 0 is ignored.
- Latency and throughput:
  - req sampled at edge t → gnt high in cycle t+1 → res_valid high from cycle t+2.
  - Earliest next arbitration is the edge after the ack.
  - Maximum throughput is one operation per 3 cycles.
- Arithmetic:
  - res = A - B modulo 2^W.
  - ovp = ~A[W-1] & B[W-1] & res[W-1].
  - ovn = A[W-1] & ~B[W-1] & ~res[W-1].
  - ovp and ovn are never both 1.
- Requests:
  - req changes during EXEC or RESP have no effect until the next IDLE.
  - A requester that drops req before being granted is simply skipped.
- Fairness: with all req held high, grants go in order 0,1,2,3,0,...; no requester waits more than NREQ-1 grants.
- Simultaneous events: res_ack and new req in the same cycle → ack is processed first; the new req is arbitrated in the following IDLE cycle.

Optional Feature:
- Macro SUB_SAT_EN.
- When defined: on ovp, res = 2^(W-1)-1; on ovn, res = -2^(W-1). ovp and ovn still report the overflow.
- When not defined: res wraps modulo 2^W.

Test Plan:
- Reset mid-RESP with res_valid = 1: raise rst → res_valid, gnt, busy and res go to 0 immediately (asynchronous); first grant after release goes to requester 0.
- Single requester 2, A = 100, B = 40 → gnt = 0100 for one cycle, then res = 60, res_id = 2, ovp = ovn = 0; A = 40, B = 100 → res = -60.
- Requester 0, A = -100, B = 40:
  - Default build: res = 116, ovn = 1, ovp = 0.
  - With SUB_SAT_EN: res = -128, ovn = 1.
- Requester 1, A = 100, B = -40:
  - Default build: res = -116, ovp = 1, ovn = 0.
  - With SUB_SAT_EN: res = 127, ovp = 1.
- All four req held high, ack on the first RESP cycle each time → res_id sequence 0,1,2,3,0; gnt pulses 3 cycles apart.
- res_ack held low for 10 cycles with other reqs pending → res, res_id and flags stable, no new gnt; ack → res_valid falls and the next requester in rr order is granted in the following IDLE.
